// File: rtl/rv32_iter_muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies with shift-add and divides with restoring division, both on
// operand magnitudes, retiring BITS_PER_CYCLE bits per iteration. Signs are
// re-applied on the final iteration as the result register is loaded.
module rv32_iter_muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            kill,
  output logic            ready,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  input  logic            result_ack
);

  localparam int B     = BITS_PER_CYCLE;
  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state_reg, state_next;

  // hi/lo: accumulator for multiply, remainder/quotient for divide.
  // opnd holds the multiplicand or the divisor magnitude.
  logic [XLEN-1:0]  hi_reg, lo_reg, opnd_reg, result_reg;
  logic [2:0]       op_reg;
  logic             neg_q_reg, neg_r_reg;
  logic [CNT_W-1:0] cnt_reg;

  // Operand decode at accept time.
  logic            is_div_in, sgn1_in, sgn2_in, neg1_in, neg2_in;
  logic [XLEN-1:0] mag1_in, mag2_in, special_result;
  logic            div_zero, div_ovf, special, accept;

  assign is_div_in = op[2];
  // Signed op1: MUL/MULH/MULHSU, DIV/REM. Signed op2: MUL/MULH, DIV/REM.
  assign sgn1_in   = is_div_in ? ~op[0] : (op[1:0] != 2'b11);
  assign sgn2_in   = is_div_in ? ~op[0] : ~op[1];
  assign neg1_in   = sgn1_in & op1[XLEN-1];
  assign neg2_in   = sgn2_in & op2[XLEN-1];
  assign mag1_in   = neg1_in ? -op1 : op1;
  assign mag2_in   = neg2_in ? -op2 : op2;

  assign div_zero  = is_div_in & (op2 == '0);
  assign div_ovf   = is_div_in & ~op[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
  assign special   = div_zero | div_ovf;
  // op[1] selects the remainder form (REM/REMU).
  assign special_result = div_zero ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);

  assign accept    = start & ~kill & (state_reg == IDLE);

  // Multiply step: add multiplicand times the low B multiplier bits, shift right by B.
  logic [XLEN+B-1:0] mul_sum;
  logic [XLEN-1:0]   mul_hi, mul_lo;

  assign mul_sum = {{B{1'b0}}, hi_reg} + ({{B{1'b0}}, opnd_reg} * {{XLEN{1'b0}}, lo_reg[B-1:0]});
  assign mul_hi  = mul_sum[XLEN+B-1:B];
  assign mul_lo  = {mul_sum[B-1:0], lo_reg[XLEN-1:B]};

  // Divide step: B chained restoring stages; a negative trial keeps the old remainder.
  logic [XLEN-1:0] div_r [0:B];
  logic [XLEN-1:0] div_q [0:B];

  assign div_r[0] = hi_reg;
  assign div_q[0] = lo_reg;

  for (genvar gi = 0; gi < B; gi++) begin : g_div
    logic [XLEN:0] trial;
    assign trial        = {div_r[gi], div_q[gi][XLEN-1]} - {1'b0, opnd_reg};
    assign div_r[gi+1]  = trial[XLEN] ? {div_r[gi][XLEN-2:0], div_q[gi][XLEN-1]}
                                      : trial[XLEN-1:0];
    assign div_q[gi+1]  = {div_q[gi][XLEN-2:0], ~trial[XLEN]};
  end

  logic [XLEN-1:0]   step_hi, step_lo, quot, remd, final_result;
  logic [2*XLEN-1:0] prod_mag, prod_signed;

  assign step_hi     = op_reg[2] ? div_r[B] : mul_hi;
  assign step_lo     = op_reg[2] ? div_q[B] : mul_lo;
  assign prod_mag    = {step_hi, step_lo};
  assign prod_signed = neg_q_reg ? -prod_mag : prod_mag;
  assign quot        = neg_q_reg ? -step_lo : step_lo;
  assign remd        = neg_r_reg ? -step_hi : step_hi;

  // Select the architectural result from the signed product / quotient / remainder.
  always_comb begin
    final_result = '0;
    case (op_reg)
      3'b000:                 final_result = prod_signed[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_result = prod_signed[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_result = quot;
      default:                final_result = remd;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic; kill outranks every other event.
  always_comb begin
    state_next = state_reg;
    if (kill) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (start) state_next = special ? DONE : CALC;
        CALC:    if (cnt_reg == CNT_W'(ITER-1)) state_next = DONE;
        DONE:    if (result_ack) state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Datapath: latch operands on accept, iterate in CALC, load result on the last iteration.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      opnd_reg   <= '0;
      result_reg <= '0;
      op_reg     <= '0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else if (accept) begin
      op_reg    <= op;
      cnt_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= is_div_in ? mag1_in : mag2_in;
      opnd_reg  <= is_div_in ? mag2_in : mag1_in;
      neg_q_reg <= neg1_in ^ neg2_in;
      neg_r_reg <= neg1_in;
      if (special) result_reg <= special_result;
    end else if (state_reg == CALC && !kill) begin
      hi_reg <= step_hi;
      lo_reg <= step_lo;
      if (cnt_reg == CNT_W'(ITER-1)) begin
        cnt_reg    <= '0;
        result_reg <= final_result;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign ready        = (state_reg == IDLE);
  assign busy         = (state_reg == CALC) || (state_reg == DONE);
  assign result_valid = (state_reg == DONE);
  assign result       = result_reg;

endmodule

// File: tb/tb_rv32_iter_muldiv_unit.sv
// Directed bench driving three unit instances (1, 2 and 4 bits per cycle)
// from shared inputs, each with its own result_ack.
module tb_rv32_iter_muldiv_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [2:0]  op_s;
  logic [31:0] op1_s, op2_s;
  logic        kill;
  logic [2:0]  ack;
  logic [2:0]  ready, busy, valid;
  logic [31:0] res_v [3];

  int checks   = 0;
  int failures = 0;

  localparam int ITERS [3] = '{32, 16, 8};

  always #5 clk = ~clk;

  rv32_iter_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_b1 (
    .clk(clk), .resetn(resetn), .start(start), .op(op_s), .op1(op1_s), .op2(op2_s),
    .kill(kill), .ready(ready[0]), .busy(busy[0]), .result_valid(valid[0]),
    .result(res_v[0]), .result_ack(ack[0]));

  rv32_iter_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(2)) u_b2 (
    .clk(clk), .resetn(resetn), .start(start), .op(op_s), .op1(op1_s), .op2(op2_s),
    .kill(kill), .ready(ready[1]), .busy(busy[1]), .result_valid(valid[1]),
    .result(res_v[1]), .result_ack(ack[1]));

  rv32_iter_muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_b4 (
    .clk(clk), .resetn(resetn), .start(start), .op(op_s), .op1(op1_s), .op2(op2_s),
    .kill(kill), .ready(ready[2]), .busy(busy[2]), .result_valid(valid[2]),
    .result(res_v[2]), .result_ack(ack[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One operation on all three instances; cycle 0 is the cycle start is presented in.
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] e, input bit sp);
    bit          got [3];
    bit          hs_bad [3];
    int          lat [3];
    logic [31:0] res [3];
    for (int k = 0; k < 3; k++) begin
      got[k] = 0; hs_bad[k] = 0; lat[k] = 0; res[k] = '0;
    end
    op_s = o; op1_s = a; op2_s = b; start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      ack   = 3'b000;
      for (int k = 0; k < 3; k++) begin
        if (!got[k]) begin
          if (busy[k] !== 1'b1 || ready[k] !== 1'b0) hs_bad[k] = 1;
          if (valid[k] === 1'b1) begin
            got[k] = 1; lat[k] = c; res[k] = res_v[k]; ack[k] = 1'b1;
          end
        end else if (c == lat[k] + 1) begin
          if (valid[k] !== 1'b0 || busy[k] !== 1'b0 || ready[k] !== 1'b1) hs_bad[k] = 1;
        end
      end
    end
    ack = 3'b000;
    for (int k = 0; k < 3; k++) begin
      $display("txn %s b%0d op=%0d a=%h b=%h result=%h latency=%0d", name, 1 << k, o, a, b,
               res[k], lat[k]);
      chk($sformatf("%s_b%0d_result", name, 1 << k), res[k], e);
      chk($sformatf("%s_b%0d_latency", name, 1 << k), lat[k], sp ? 32'd1 : 32'(ITERS[k] + 1));
      chk($sformatf("%s_b%0d_handshake", name, 1 << k), {31'b0, hs_bad[k]}, 32'd0);
    end
  endtask

  int   cyc;
  bit   stable_bad;
  logic [2:0] seen;

  initial begin
    resetn = 1'b0; start = 1'b0; kill = 1'b0; ack = 3'b000;
    op_s = 3'b000; op1_s = '0; op2_s = '0;
    #1;
    chk("reset_ready", {29'b0, ready}, 32'h7);
    chk("reset_busy",  {29'b0, busy},  32'h0);
    chk("reset_valid", {29'b0, valid}, 32'h0);
    chk("reset_result", res_v[0] | res_v[1] | res_v[2], 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;

    run_op("MUL",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0);
    run_op("MULH",    3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("MULHU",   3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 0);
    run_op("MULHSU",  3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("MULHU_FF",3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0);
    run_op("DIV",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0);
    run_op("REM",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0);
    run_op("DIVU",    3'b101, 32'd100,      32'd7,        32'd14,       0);
    run_op("REMU",    3'b111, 32'd100,      32'd7,        32'd2,        0);
    run_op("DIV_NEGD",3'b100, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 0);
    run_op("REM_NEGD",3'b110, 32'd100,      32'hFFFFFFF9, 32'd2,        0);
    run_op("DIVU_Z",  3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1);
    run_op("REMU_Z",  3'b111, 32'd100,      32'd0,        32'd100,      1);
    run_op("DIV_OVF", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("REM_OVF", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("DIV_Z",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("REM_Z",   3'b110, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 1);

    // start together with kill in IDLE is not accepted
    op_s = 3'b000; op1_s = 32'd7; op2_s = 32'd3; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    $display("txn start_with_kill ready=%b busy=%b", ready, busy);
    chk("startkill_ready", {29'b0, ready}, 32'h7);
    chk("startkill_busy",  {29'b0, busy},  32'h0);

    // kill at iteration 10 of the 1-bit instance
    seen = 3'b000; start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      seen  = seen | valid;
      if (c == 11) kill = 1'b1;
    end
    kill = 1'b0;
    $display("txn kill ready=%b valid=%b seen=%b", ready, valid, seen);
    chk("kill_ready", {29'b0, ready}, 32'h7);
    chk("kill_valid", {29'b0, valid}, 32'h0);
    chk("kill_never_valid", {30'b0, seen[1:0]}, 32'h0);
    run_op("MUL_AFTER_KILL", 3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 0);

    // back-pressure: hold result_ack low in DONE, pulse start meanwhile
    op_s = 3'b101; op1_s = 32'd100; op2_s = 32'd7; start = 1'b1; ack = 3'b000;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end while (valid[0] !== 1'b1 && cyc < 40);
    chk("bp_latency", cyc, 32'd33);
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin start = 1'b1; op1_s = 32'd200; end
      @(posedge clk); #1;
      start = 1'b0;
      if (valid !== 3'b111 || busy !== 3'b111 || res_v[0] !== 32'd14 ||
          res_v[1] !== 32'd14 || res_v[2] !== 32'd14) stable_bad = 1;
    end
    $display("txn backpressure result=%h valid=%b", res_v[0], valid);
    chk("bp_stable", {31'b0, stable_bad}, 32'd0);
    ack = 3'b111; start = 1'b1;
    @(posedge clk); #1;
    ack = 3'b000; start = 1'b0;
    chk("bp_ack_ready", {29'b0, ready}, 32'h7);
    chk("bp_ack_valid", {29'b0, valid}, 32'h0);
    @(posedge clk); #1;
    chk("bp_not_queued", {29'b0, busy}, 32'h0);

    // asynchronous reset in the middle of CALC
    op_s = 3'b000; op1_s = 32'd7; op2_s = 32'hFFFFFFFD; start = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2 resetn = 1'b0;
    #1;
    $display("txn reset_mid ready=%b busy=%b valid=%b result=%h", ready, busy, valid, res_v[0]);
    chk("rstmid_ready", {29'b0, ready}, 32'h7);
    chk("rstmid_busy",  {29'b0, busy},  32'h0);
    chk("rstmid_valid", {29'b0, valid}, 32'h0);
    chk("rstmid_result", res_v[0] | res_v[1] | res_v[2], 32'h0);
    @(posedge clk); #1;
    resetn = 1'b1;
    run_op("REMU_AFTER_RST", 3'b111, 32'd100, 32'd7, 32'd2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
